imem_boot_loader: RTL and testbench

Streams a program image from a byte-serial source, such as a UART receiver, into instruction memory before the processor runs. It sits directly upstream of the processor/memory top level. It drives the imem write port and holds the processor's reset asserted until a complete image has been written and its checksum has passed. The release is then delayed so that reset spans at least one edge of the divided processor clock.

---
 rtl/boot_loader_pkg.sv | 20 ++
 rtl/boot_word_assembler.sv | 51 +++++
 rtl/imem_boot_loader.sv | 139 +++++++++++++
 tb/tb_imem_boot_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_PAYLOAD,
    ST_CHECK,
    ST_RELEASE,
    ST_RUN,
    ST_ERROR
  } state_e;

  localparam int HDR_BYTES             = 2;
  localparam int BYTES_PER_WORD        = 4;
  localparam int LEN_WIDTH             = 8 * HDR_BYTES;
  localparam int DEFAULT_RELEASE_DELAY = 8;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs big-endian payload bytes into imem words; owns the registered write data.
module boot_word_assembler
  import boot_loader_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_in,
  output logic                          word_done,
  output logic [8*BYTES_PER_WORD-1:0]   word_data
);

  localparam int IDX_W   = $clog2(BYTES_PER_WORD);
  localparam int SHIFT_W = 8 * (BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]            idx_q,   idx_d;
  logic [SHIFT_W-1:0]          shift_q, shift_d;
  logic [8*BYTES_PER_WORD-1:0] data_q,  data_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    word_done = byte_valid && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    if (clear) begin
      idx_d = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[SHIFT_W-9:0], byte_in};
      idx_d   = idx_q + 1'b1;
      if (word_done) data_d = {shift_q, byte_in};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
    end
  end

  assign word_data = data_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into imem and holds
// the processor in reset until the image is written and verified.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int RELEASE_DELAY = DEFAULT_RELEASE_DELAY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  rx_ready,
  output logic                  imem_wren,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [DATA_WIDTH-1:0] imem_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int          CNT_W     = $clog2(RELEASE_DELAY + 1);
  localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;

  state_e                 state_q, state_d;
  logic [7:0]             acc_q, acc_d;
  logic [7:0]             len_hi_q, len_hi_d;
  logic [LEN_WIDTH-1:0]   words_left_q, words_left_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic                   wren_q, wren_d;
  logic [CNT_W-1:0]       rel_cnt_q, rel_cnt_d;

  logic                   byte_accept;
  logic                   restart;
  logic                   word_done;
  logic [LEN_WIDTH-1:0]   len_n;

  assign byte_accept = rx_valid && rx_ready;
  assign restart     = start && (state_q inside {ST_IDLE, ST_RUN, ST_ERROR});
  assign len_n       = {len_hi_q, rx_byte};

  boot_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (byte_accept && (state_q == ST_PAYLOAD)),
    .byte_in    (rx_byte),
    .word_done  (word_done),
    .word_data  (imem_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: if (start) state_d = ST_LEN_HI;
      ST_LEN_HI:  if (byte_accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (byte_accept) begin
          if (32'(len_n) > MAX_WORDS) state_d = ST_ERROR;
          else if (len_n == '0)       state_d = ST_CHECK;
          else                        state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (word_done && words_left_q == LEN_WIDTH'(1)) state_d = ST_CHECK;
      ST_CHECK:   if (byte_accept) state_d = (rx_byte == acc_q) ? ST_RELEASE : ST_ERROR;
      ST_RELEASE: if (rel_cnt_q == CNT_W'(RELEASE_DELAY)) state_d = ST_RUN;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register, so they change only on clock edges.
  always_comb begin
    rx_ready  = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_PAYLOAD, ST_CHECK};
    busy      = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_PAYLOAD, ST_CHECK, ST_RELEASE};
    done      = (state_q == ST_RUN);
    error     = (state_q == ST_ERROR);
    cpu_reset = (state_q != ST_RUN);
  end

  always_comb begin
    acc_d        = acc_q;
    len_hi_d     = len_hi_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    wr_addr_d    = wr_addr_q;
    wren_d       = word_done;
    rel_cnt_d    = (state_q == ST_RELEASE) ? rel_cnt_q + 1'b1 : '0;

    if (restart) begin
      acc_d  = '0;
      addr_d = '0;
    end else if (byte_accept && state_q != ST_CHECK) begin
      acc_d = acc_q ^ rx_byte;
    end

    if (byte_accept && state_q == ST_LEN_HI) len_hi_d     = rx_byte;
    if (byte_accept && state_q == ST_LEN_LO) words_left_d = len_n;

    // Latch the write address so it stays on the port while the counter moves on.
    if (word_done) begin
      words_left_d = words_left_q - 1'b1;
      wr_addr_d    = addr_q;
      addr_d       = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q        <= '0;
      len_hi_q     <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      wren_q       <= 1'b0;
      rel_cnt_q    <= '0;
    end else begin
      acc_q        <= acc_d;
      len_hi_q     <= len_hi_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      wren_q       <= wren_d;
      rel_cnt_q    <= rel_cnt_d;
    end
  end

  assign imem_wren    = wren_q;
  assign imem_address = wr_addr_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as frames
// are driven and compared against writes captured from the imem port.
module tb_imem_boot_loader;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RD = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          rx_ready, imem_wren, cpu_reset, busy, done, error;
  logic [AW-1:0] imem_address;
  logic [DW-1:0] imem_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [31:0] img [0:4095];

  imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RELEASE_DELAY(RD)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_ready     (rx_ready),
    .imem_wren    (imem_wren),
    .imem_address (imem_address),
    .imem_data    (imem_data),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge clock)
    if (imem_wren === 1'b1) obs_q.push_back(wr_t'({imem_address, imem_data}));

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(posedge clock); #1;
    end
    rx_valid = 1'b1;
    rx_byte  = b;
    n = 0;
    forever begin
      @(negedge clock);
      if (rx_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_byte_timeout: rx_ready stayed %b, required 1", rx_ready);
        break;
      end
    end
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit bad, input int max_gap, input int start_at);
    logic [7:0]  bytes[$];
    logic [7:0]  cks;
    logic [15:0] len;
    logic [31:0] w;
    len = 16'(n);
    bytes.push_back(len[15:8]);
    bytes.push_back(len[7:0]);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      bytes.push_back(w[31:24]); bytes.push_back(w[23:16]);
      bytes.push_back(w[15:8]);  bytes.push_back(w[7:0]);
      exp_q.push_back(wr_t'({AW'(i), w}));
    end
    cks = '0;
    foreach (bytes[i]) cks ^= bytes[i];
    bytes.push_back(bad ? (cks ^ 8'h5A) : cks);
    foreach (bytes[i]) begin
      if (i == start_at) begin
        rx_valid = 1'b0;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
      end
      send_byte(bytes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic wait_release(input string name);
    int k = 0;
    checks++;
    if (cpu_reset !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_release_entry: cpu_reset=%b busy=%b, required 1 1", name, cpu_reset, busy);
    end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (cpu_reset === 1'b0) begin k = i; break; end
    end
    checks++;
    if (k != RD + 1) begin
      errors++;
      $display("FAIL %s_release_cycles: got %0d, required %0d", name, k, RD + 1);
    end
    checks++;
    if ({done, busy, error, rx_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_run_flags: done/busy/error/rx_ready=%b, required 1000", name, {done, busy, error, rx_ready});
    end
  endtask

  task automatic compare_writes(input string name);
    wr_t o, e;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d, required %0d", name, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s_write: got addr=%h data=%h, required addr=%h data=%h", name, o.addr, o.data, e.addr, e.data);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({cpu_reset, rx_ready, imem_wren, busy, done, error} !== 6'b100000 ||
        imem_address !== '0 || imem_data !== '0) begin
      errors++;
      $display("FAIL %s: cpu_reset/rx_ready/wren/busy/done/error=%b addr=%h data=%h, required 100000 0 0",
               name, {cpu_reset, rx_ready, imem_wren, busy, done, error}, imem_address, imem_data);
    end
  endtask

  task automatic test_reset();
    #2;
    check_reset_outputs("reset_asserted");
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset_idle");
  endtask

  task automatic test_single();
    logic [7:0] fr [7];
    fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    pulse_start();
    checks++;
    if ({rx_ready, busy, cpu_reset, done} !== 4'b1110) begin
      errors++;
      $display("FAIL single_after_start: rx_ready/busy/cpu_reset/done=%b, required 1110", {rx_ready, busy, cpu_reset, done});
    end
    exp_q.push_back(wr_t'({AW'(0), 32'h1234_5678}));
    for (int i = 0; i < 6; i++) send_byte(fr[i], 0);
    checks++;
    if (imem_wren !== 1'b1 || imem_address !== AW'(0) || imem_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL single_wren_pulse: wren=%b addr=%h data=%h, required 1 000 12345678", imem_wren, imem_address, imem_data);
    end
    send_byte(fr[6], 0);
    checks++;
    if (imem_wren !== 1'b0) begin
      errors++;
      $display("FAIL single_wren_width: wren=%b, required 0", imem_wren);
    end
    wait_release("single");
    compare_writes("single");
  endtask

  task automatic test_bad_checksum();
    logic [7:0] fr [7];
    fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
    pulse_start();
    exp_q.push_back(wr_t'({AW'(0), 32'h1234_5678}));
    foreach (fr[i]) send_byte(fr[i], 0);
    repeat (20) @(posedge clock);
    #1;
    checks++;
    if ({error, cpu_reset, done, busy, rx_ready} !== 5'b11000) begin
      errors++;
      $display("FAIL bad_cks_flags: error/cpu_reset/done/busy/rx_ready=%b, required 11000", {error, cpu_reset, done, busy, rx_ready});
    end
    compare_writes("bad_cks");
    pulse_start();
    checks++;
    if ({error, busy, rx_ready, cpu_reset} !== 4'b0111) begin
      errors++;
      $display("FAIL bad_cks_restart: error/busy/rx_ready/cpu_reset=%b, required 0111", {error, busy, rx_ready, cpu_reset});
    end
    send_frame(1, 1'b0, 0, -1);
    wait_release("bad_cks_reload");
    compare_writes("bad_cks_reload");
  endtask

  task automatic test_zero();
    pulse_start();
    send_frame(0, 1'b0, 0, -1);
    wait_release("zero");
    compare_writes("zero");
  endtask

  task automatic test_too_long();
    pulse_start();
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    checks++;
    if ({error, rx_ready, busy, cpu_reset, done} !== 5'b10010) begin
      errors++;
      $display("FAIL too_long_flags: error/rx_ready/busy/cpu_reset/done=%b, required 10010", {error, rx_ready, busy, cpu_reset, done});
    end
    repeat (5) @(posedge clock);
    #1;
    compare_writes("too_long");
  endtask

  task automatic test_full();
    int c0;
    for (int i = 0; i < 4096; i++) img[i] = $urandom;
    pulse_start();
    c0 = cyc;
    send_frame(4096, 1'b0, 0, -1);
    checks++;
    if (cyc - c0 != 4 * 4096 + 3) begin
      errors++;
      $display("FAIL full_rate_cycles: got %0d, required %0d", cyc - c0, 4 * 4096 + 3);
    end
    wait_release("full");
    compare_writes("full");
  endtask

  task automatic test_gaps();
    pulse_start();
    send_frame(8, 1'b0, 0, -1);
    wait_release("nogap");
    compare_writes("nogap");
    pulse_start();
    send_frame(8, 1'b0, 3, 13);
    wait_release("gaps");
    compare_writes("gaps");
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 0);
    exp_q.push_back(wr_t'({AW'(0), 32'hA0A1_A2A3}));
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset_async");
    compare_writes("mid_reset");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    pulse_start();
    send_frame(4, 1'b0, 0, -1);
    wait_release("after_reset");
    compare_writes("after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_checksum();
    test_zero();
    test_too_long();
    test_full();
    test_gaps();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
